// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides, a registered-read RAM,
// a one-word prefetch stage and an output holding register for zero-bubble streaming.
module stream_fifo #(
    parameter int unsigned WORD_SIZE           = 8,
    parameter int unsigned ADDR_WIDTH          = 8,
    parameter int unsigned NUM_WORDS           = 256,
    parameter int unsigned ALMOST_FULL         = NUM_WORDS - 4,
    parameter int unsigned USE_XILINX_BLOCKRAM = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_SIZE-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_SIZE-1:0]  out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  empty
);

    localparam logic [ADDR_WIDTH:0]   FullCount   = (ADDR_WIDTH + 1)'(NUM_WORDS);
    localparam logic [ADDR_WIDTH:0]   AlmostCount = (ADDR_WIDTH + 1)'(ALMOST_FULL);
    localparam logic [ADDR_WIDTH-1:0] LastAddr    = ADDR_WIDTH'(NUM_WORDS - 1);

    logic [WORD_SIZE-1:0]  mem [NUM_WORDS];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q, ram_level;
    logic                  stage_valid_q, out_valid_q;
    logic [WORD_SIZE-1:0]  stage_data_q, out_data_q;
    logic                  clear, push, pop, out_load, rd_en;

    assign clear    = ~reset_n | flush;
    assign in_ready = (count_q != FullCount) & ~flush & reset_n;
    assign push     = in_valid & in_ready;
    assign pop      = out_valid_q & out_ready & ~clear;
    // The prefetch stage moves into the output register whenever that register frees up.
    assign out_load = stage_valid_q & (~out_valid_q | pop);
    // Words still sitting in the RAM, not yet read into the prefetch stage.
    assign ram_level = count_q - (ADDR_WIDTH + 1)'(stage_valid_q)
                               - (ADDR_WIDTH + 1)'(out_valid_q);
    // Only words written on an earlier edge are read, so a same-address write is never seen early.
    assign rd_en = ~clear & (ram_level != '0) & (~stage_valid_q | out_load);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    generate
        if (USE_XILINX_BLOCKRAM != 0) begin : g_block_ram
            always_ff @(posedge clk) begin
                if (rd_en) begin
                    stage_data_q <= mem[rd_ptr_q];
                end
            end
        end else begin : g_dist_ram
            logic [WORD_SIZE-1:0] ram_rd_word;
            assign ram_rd_word = mem[rd_ptr_q];
            always_ff @(posedge clk) begin
                if (rd_en) begin
                    stage_data_q <= ram_rd_word;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            stage_valid_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (ADDR_WIDTH + 1)'(push) - (ADDR_WIDTH + 1)'(pop);
            if (out_load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= stage_data_q;
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
            if (rd_en) begin
                stage_valid_q <= 1'b1;
            end else if (out_load) begin
                stage_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign count       = count_q;
    assign almost_full = count_q >= AlmostCount;
    assign empty       = count_q == '0;

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo: a 256-word and a 5-word instance driven by directed and random
// handshakes, checked against a queue model with push timestamps.
module tb_stream_fifo;

    logic       clk = 1'b0;
    logic       iv [2];
    logic       ordy [2];
    logic       fl [2];
    logic       rn [2];
    logic [7:0] din [2];
    logic       ir [2];
    logic       ov [2];
    logic       af [2];
    logic       em [2];
    logic [7:0] od0, od1;
    logic [8:0] cnt0;
    logic [3:0] cnt1;

    int checks = 0;
    int errors = 0;

    // Model: every word ever pushed is stored with the edge number of its push.
    int         cap [2]  = '{256, 5};
    int         afth [2] = '{252, 1};
    logic [7:0] mdat [2][8192];
    int         medge [2][8192];
    int         wr_i [2];
    int         rd_i [2];
    bit         zero_out [2];
    int         ecnt = 0;

    always #5 clk = ~clk;

    stream_fifo u_big (
        .clk(clk), .reset_n(rn[0]), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(din[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0),
        .count(cnt0), .almost_full(af[0]), .empty(em[0])
    );

    stream_fifo #(.ADDR_WIDTH(3), .NUM_WORDS(5)) u_small (
        .clk(clk), .reset_n(rn[1]), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(din[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1),
        .count(cnt1), .almost_full(af[1]), .empty(em[1])
    );

    function automatic int m_cnt(int d);
        return wr_i[d] - rd_i[d];
    endfunction

    function automatic bit m_inr(int d);
        return (m_cnt(d) != cap[d]) && !fl[d] && rn[d];
    endfunction

    // The head word is visible once two edges have passed since its push.
    function automatic bit m_ov(int d);
        return (m_cnt(d) != 0) && (ecnt - medge[d][rd_i[d] % 8192] >= 2);
    endfunction

    task automatic chk(string tag, int d, int got, int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed %0d expected %0d", tag, d, got, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            int got_cnt;
            int got_od;
            got_cnt = (d == 0) ? int'(cnt0) : int'(cnt1);
            got_od  = (d == 0) ? int'(od0) : int'(od1);
            chk("count", d, got_cnt, m_cnt(d));
            chk("in_ready", d, int'(ir[d]), int'(m_inr(d)));
            chk("out_valid", d, int'(ov[d]), int'(m_ov(d)));
            chk("empty", d, int'(em[d]), int'(m_cnt(d) == 0));
            chk("almost_full", d, int'(af[d]), int'(m_cnt(d) >= afth[d]));
            if (m_ov(d)) begin
                chk("out_data", d, got_od, int'(mdat[d][rd_i[d] % 8192]));
                zero_out[d] = 1'b0;
            end else if (zero_out[d]) begin
                chk("out_data_reset", d, got_od, 0);
            end
        end
    endtask

    task automatic cycle();
        bit pu [2];
        bit po [2];
        for (int d = 0; d < 2; d++) begin
            pu[d] = iv[d] && m_inr(d);
            po[d] = m_ov(d) && ordy[d] && !fl[d] && rn[d];
        end
        @(posedge clk);
        ecnt++;
        for (int d = 0; d < 2; d++) begin
            if (!rn[d] || fl[d]) begin
                rd_i[d] = wr_i[d];
                if (!rn[d]) zero_out[d] = 1'b1;
            end else begin
                if (po[d]) rd_i[d]++;
                if (pu[d]) begin
                    mdat[d][wr_i[d] % 8192]  = din[d];
                    medge[d][wr_i[d] % 8192] = ecnt;
                    wr_i[d]++;
                end
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle_all();
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b0; fl[d] = 1'b0; rn[d] = 1'b1; din[d] = 8'h00;
        end
    endtask

    initial begin
        int k;
        for (int d = 0; d < 2; d++) begin
            wr_i[d] = 0; rd_i[d] = 0; zero_out[d] = 1'b1;
        end
        idle_all();
        rn[0] = 1'b0; rn[1] = 1'b0;
        repeat (3) cycle();
        rn[0] = 1'b1; rn[1] = 1'b1;
        cycle();

        // Single word latency on an empty FIFO.
        din[0] = 8'h11; iv[0] = 1'b1;
        cycle();
        iv[0] = 1'b0;
        cycle();
        cycle();
        chk("t1_valid", 0, int'(ov[0]), 1);
        chk("t1_data", 0, int'(od0), 8'h11);
        chk("t1_count", 0, int'(cnt0), 1);
        ordy[0] = 1'b1;
        repeat (2) cycle();
        ordy[0] = 1'b0;

        // Fill 256 words with the consumer stalled, then drain back to back.
        k = 0;
        iv[0] = 1'b1;
        repeat (260) begin
            din[0] = 8'(k);
            if (m_inr(0)) k++;
            cycle();
        end
        iv[0] = 1'b0;
        chk("t2_full_count", 0, int'(cnt0), 256);
        chk("t2_full_ready", 0, int'(ir[0]), 0);
        ordy[0] = 1'b1;
        repeat (260) cycle();
        ordy[0] = 1'b0;
        chk("t2_drained", 0, int'(cnt0), 0);

        // Random handshakes on the 5-word instance across many pointer wraps.
        repeat (80) begin
            iv[1] = 1'($urandom % 2); ordy[1] = 1'($urandom % 2); din[1] = 8'($urandom);
            cycle();
            checks++;
            assert (int'(cnt1) <= 5) else begin
                errors++;
                $error("FAIL t3_bound dut1 observed %0d expected <= 5", cnt1);
            end
        end
        iv[1] = 1'b0; ordy[1] = 1'b1;
        repeat (8) cycle();
        ordy[1] = 1'b0;

        // Fill to 3, then simultaneous push and pop for 10 cycles.
        iv[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din[1] = 8'(8'h40 + i);
            cycle();
        end
        iv[1] = 1'b0;
        repeat (2) cycle();
        iv[1] = 1'b1; ordy[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din[1] = 8'(8'h50 + i);
            cycle();
        end
        chk("t4_count", 1, int'(cnt1), 3);
        iv[1] = 1'b0;
        repeat (6) cycle();
        ordy[1] = 1'b0;

        // Flush with a push and pop offered on the same edge.
        iv[0] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            din[0] = 8'(8'h70 + i);
            cycle();
        end
        iv[0] = 1'b0;
        repeat (2) cycle();
        fl[0] = 1'b1; iv[0] = 1'b1; ordy[0] = 1'b1; din[0] = 8'hEE;
        cycle();
        fl[0] = 1'b0; iv[0] = 1'b0; ordy[0] = 1'b0;
        chk("t5_count", 0, int'(cnt0), 0);
        chk("t5_valid", 0, int'(ov[0]), 0);
        chk("t5_empty", 0, int'(em[0]), 1);
        din[0] = 8'h3C; iv[0] = 1'b1;
        cycle();
        iv[0] = 1'b0;
        repeat (2) cycle();
        ordy[0] = 1'b1;
        repeat (2) cycle();
        ordy[0] = 1'b0;

        // Reset mid-stream with 10 words stored.
        iv[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din[0] = 8'(8'h90 + i);
            cycle();
        end
        rn[0] = 1'b0; ordy[0] = 1'b1; din[0] = 8'hFF;
        cycle();
        chk("t6_count", 0, int'(cnt0), 0);
        chk("t6_data", 0, int'(od0), 0);
        rn[0] = 1'b1; ordy[0] = 1'b0; din[0] = 8'hA5;
        cycle();
        iv[0] = 1'b0;
        cycle();
        cycle();
        chk("t6_a5", 0, int'(od0), 8'hA5);
        chk("t6_count1", 0, int'(cnt0), 1);
        ordy[0] = 1'b1;
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
